// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor slice.
// Holds the 2-bit counter encoding, the PC width and the default sizes.
// No logic; imported by the interface, the counter and the top.
package bp_pkg;

  localparam int PC_W            = 16;
  localparam int DEF_NUM_ENTRIES = 8;
  localparam int DEF_STAT_W      = 16;

  // Direction counter; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / decode-update bundle between the pipeline and the predictor.
// Purely wires; timing is set by the modules on either side.
// No backpressure: the pipeline gates enable/wen itself while stalled.
//   master : pipeline side (drives fetch PC and resolved-branch info)
//   slave  : predictor side (drives prediction, flush request, statistics)
interface branch_predictor_if
  import bp_pkg::*;
#(
  parameter int STAT_W = DEF_STAT_W
);

  logic              enable;
  logic [PC_W-1:0]   PC_curr;
  logic              wen;
  logic [PC_W-1:0]   IF_ID_PC_curr;
  logic              IF_ID_predicted_taken;
  logic [PC_W-1:0]   IF_ID_predicted_target;
  logic              actual_taken;
  logic [PC_W-1:0]   actual_target;
  logic              predicted_taken;
  logic [PC_W-1:0]   predicted_target;
  logic              mispredicted;
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispredict_count;

  modport master (
    output enable, PC_curr, wen, IF_ID_PC_curr, IF_ID_predicted_taken,
           IF_ID_predicted_target, actual_taken, actual_target,
    input  predicted_taken, predicted_target, mispredicted,
           branch_count, mispredict_count
  );

  modport slave (
    input  enable, PC_curr, wen, IF_ID_PC_curr, IF_ID_predicted_taken,
           IF_ID_predicted_target, actual_taken, actual_target,
    output predicted_taken, predicted_target, mispredicted,
           branch_count, mispredict_count
  );

endinterface

// File: rtl/sat_counter_2b.sv
// 2-bit saturating direction counter next-state function.
// Combinational, 0 cycles.
// No backpressure.
//   state/taken in, next_state out; saturates at STRONG_T and STRONG_NT.
module sat_counter_2b
  import bp_pkg::*;
(
  input  ctr_e state,
  input  logic taken,
  output ctr_e next_state
);

  always_comb begin
    next_state = state;
    unique case (state)
      STRONG_NT: next_state = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next_state = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    next_state = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  next_state = taken ? STRONG_T : WEAK_T;
      default:   next_state = state;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and branch statistics.
// Lookup and mispredict flag are combinational; table updates on the next clk.
// No backpressure: enable/wen are gated upstream while the pipe is stalled.
//   clk, rst_n (sync, active-low) plain ports; everything else on bus (slave).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int STAT_W      = DEF_STAT_W
) (
  input logic              clk,
  input logic              rst_n,
  branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 1;
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic             valid_q  [NUM_ENTRIES];
  logic [TAG_W-1:0] tag_q    [NUM_ENTRIES];
  logic [PC_W-1:0]  target_q [NUM_ENTRIES];
  ctr_e             ctr_q    [NUM_ENTRIES];

  logic [STAT_W-1:0] branch_count_q;
  logic [STAT_W-1:0] mispredict_count_q;

  // PC bit 0 never selects an instruction slot.
  logic pc_lsb_unused;
  assign pc_lsb_unused = bus.PC_curr[0] ^ bus.IF_ID_PC_curr[0];

  // Fetch-side lookup reads registered state only, so a same-cycle update
  // to the same index is not visible until the following cycle.
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  assign rd_idx = bus.PC_curr[IDX_W:1];
  assign rd_tag = bus.PC_curr[PC_W-1:IDX_W+1];
  assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign bus.predicted_taken  = bus.enable && rd_hit && ctr_q[rd_idx][1];
  assign bus.predicted_target = bus.predicted_taken ? target_q[rd_idx] : '0;

  // Flush when direction was wrong, or when taken but sent to the wrong place.
  assign bus.mispredicted = bus.wen &&
      ((bus.actual_taken != bus.IF_ID_predicted_taken) ||
       (bus.actual_taken && (bus.actual_target != bus.IF_ID_predicted_target)));

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  ctr_e             wr_ctr_next;
  assign wr_idx = bus.IF_ID_PC_curr[IDX_W:1];
  assign wr_tag = bus.IF_ID_PC_curr[PC_W-1:IDX_W+1];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  sat_counter_2b u_sat_counter (
    .state      (ctr_q[wr_idx]),
    .taken      (bus.actual_taken),
    .next_state (wr_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (bus.wen) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= wr_ctr_next;
        if (bus.actual_taken) target_q[wr_idx] <= bus.actual_target;
      end else begin
        // Miss (cold or tag alias): replace the entry, start weakly biased.
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= bus.actual_target;
        ctr_q[wr_idx]    <= bus.actual_taken ? WEAK_T : WEAK_NT;
      end
      if (branch_count_q != '1)
        branch_count_q <= branch_count_q + STAT_ONE;
      if (bus.mispredicted && (mispredict_count_q != '1))
        mispredict_count_q <= mispredict_count_q + STAT_ONE;
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int N      = 8;
  localparam int LOG2N  = 3;
  localparam int SW     = 4;   // narrow statistics so saturation is reached
  localparam int SMAX   = (1 << SW) - 1;

  logic clk;
  logic rst_n;

  branch_predictor_if #(.STAT_W(SW)) bus ();

  branch_predictor #(.NUM_ENTRIES(N), .STAT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one record per slot, counter as an integer 0..3.
  bit m_val [N];
  int m_tag [N];
  int m_tgt [N];
  int m_cnt [N];
  int m_bc, m_mc;

  typedef struct {
    bit          pt;
    logic [15:0] tgt;
    bit          mis;
    int          bc;
    int          mc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Inputs applied in the previous cycle, folded into the model at the edge.
  bit   have_prev = 0;
  bit   p_rn, p_w, p_at, p_mis;
  int   p_ipc, p_atg;

  function automatic int idx_of(int pc);
    return (pc >> 1) % N;
  endfunction

  function automatic int tag_of(int pc);
    return pc >> (LOG2N + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic model_edge();
    int i;
    if (!p_rn) begin
      model_reset();
      return;
    end
    if (!p_w) return;
    i = idx_of(p_ipc);
    if (m_val[i] && m_tag[i] == tag_of(p_ipc)) begin
      m_cnt[i] = p_at ? ((m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1)
                      : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
      if (p_at) m_tgt[i] = p_atg;
    end else begin
      m_val[i] = 1;
      m_tag[i] = tag_of(p_ipc);
      m_tgt[i] = p_atg;
      m_cnt[i] = p_at ? 2 : 1;
    end
    if (m_bc < SMAX) m_bc++;
    if (p_mis && m_mc < SMAX) m_mc++;
  endtask

  task automatic step(input bit rn, input bit en, input int pc, input bit w,
                      input int ipc, input bit ipt, input int iptg,
                      input bit at, input int atg);
    exp_t e;
    int   i;
    @(posedge clk);
    if (have_prev) model_edge();
    #1;
    rst_n                      = rn;
    bus.enable                 = en;
    bus.PC_curr                = 16'(pc);
    bus.wen                    = w;
    bus.IF_ID_PC_curr          = 16'(ipc);
    bus.IF_ID_predicted_taken  = ipt;
    bus.IF_ID_predicted_target = 16'(iptg);
    bus.actual_taken           = at;
    bus.actual_target          = 16'(atg);
    i       = idx_of(pc);
    e.pt    = en && m_val[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
    e.tgt   = e.pt ? 16'(m_tgt[i]) : 16'h0000;
    e.mis   = w && ((at != ipt) || (at && (atg != iptg)));
    e.bc    = m_bc;
    e.mc    = m_mc;
    p_rn = rn; p_w = w; p_at = at; p_mis = e.mis; p_ipc = ipc; p_atg = atg;
    have_prev = 1;
    #1;
    exp_q.push_back(e);
  endtask

  task automatic lookup(input int pc);
    step(1, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  // Resolve a branch at pc while fetch looks up the same pc.
  task automatic resolve(input int pc, input bit at, input int atg);
    step(1, 1, pc, 1, pc, 0, 0, at, atg);
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (bus.predicted_taken !== e.pt) begin
          miscompares++;
          $display("FAIL predicted_taken @%0t: got %b want %b", $time, bus.predicted_taken, e.pt);
        end
        if (bus.predicted_target !== e.tgt) begin
          miscompares++;
          $display("FAIL predicted_target @%0t: got %h want %h", $time, bus.predicted_target, e.tgt);
        end
        if (bus.mispredicted !== e.mis) begin
          miscompares++;
          $display("FAIL mispredicted @%0t: got %b want %b", $time, bus.mispredicted, e.mis);
        end
        if (int'(bus.branch_count) != e.bc || $isunknown(bus.branch_count)) begin
          miscompares++;
          $display("FAIL branch_count @%0t: got %0d want %0d", $time, bus.branch_count, e.bc);
        end
        if (int'(bus.mispredict_count) != e.mc || $isunknown(bus.mispredict_count)) begin
          miscompares++;
          $display("FAIL mispredict_count @%0t: got %0d want %0d", $time, bus.mispredict_count, e.mc);
        end
      end
    end
  end

  initial begin
    int pool_pc, pool_ipc, atg;
    bit at;
    rst_n = 1'b0;
    bus.enable = 0; bus.PC_curr = '0; bus.wen = 0; bus.IF_ID_PC_curr = '0;
    bus.IF_ID_predicted_taken = 0; bus.IF_ID_predicted_target = '0;
    bus.actual_taken = 0; bus.actual_target = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Held in reset: lookups and statistics are zero, flush flag stays combinational.
    step(0, 1, 16'h0010, 1, 16'h0010, 0, 0, 1, 16'h0040);

    // Cold lookup misses.
    lookup(16'h0010);

    // First taken branch: flush, allocate, then predicted taken to 0x0040.
    step(1, 1, 16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0040);
    lookup(16'h0010);

    // Reset on an update cycle drops the update and clears statistics.
    step(0, 1, 16'h0010, 1, 16'h0010, 0, 0, 1, 16'h0080);
    lookup(16'h0010);
    lookup(16'h0012);

    // Counter walk: four taken then three not taken.
    for (int k = 0; k < 4; k++) resolve(16'h0010, 1, 16'h0040 + 16 * k);
    for (int k = 0; k < 3; k++) resolve(16'h0010, 0, 16'h0100);
    lookup(16'h0010);

    // Tag alias at index 0 replaces the entry; the original PC then misses.
    resolve(16'h0010, 1, 16'h0200);
    resolve(16'h0110, 0, 16'h0300);
    lookup(16'h0010);
    lookup(16'h0110);

    // Same-index update and lookup: old contents this cycle, new next cycle.
    resolve(16'h0110, 1, 16'h0444);
    resolve(16'h0110, 1, 16'h0555);
    lookup(16'h0110);
    // enable low hides the prediction and leaves the table alone.
    step(1, 0, 16'h0110, 0, 0, 0, 0, 0, 0);
    lookup(16'h0110);

    // PC bit 0 is ignored.
    lookup(16'h0111);

    // Random traffic over a small PC pool so hits, aliases and saturation occur.
    for (int k = 0; k < 400; k++) begin
      pool_pc  = ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1);
      pool_ipc = ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1);
      at  = $urandom_range(0, 1);
      atg = $urandom_range(0, 3) * 16'h0100;
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) != 0), pool_pc,
           ($urandom_range(0, 4) < 3), pool_ipc, $urandom_range(0, 1),
           ($urandom_range(0, 1) ? atg : $urandom_range(0, 3) * 16'h0100), at, atg);
    end

    // Drain: every issued vector must have been checked within a bounded wait.
    for (int t = 0; t < 4 && exp_q.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
